// File: rtl/axis_stall_pkg.sv
// Shared constants and helpers for the AXI-Stream stall detector.
package axis_stall_pkg;

    localparam logic STALL_IN  = 1'b0;
    localparam logic STALL_OUT = 1'b1;

    localparam int BLOCK_CNT_W = 32;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_stall_counter.sv
// One watched stream: stall predicate, saturating stall counter and blocked flag.
module axis_stall_counter
    import axis_stall_pkg::*;
#(
    parameter logic IS_OUT       = STALL_IN,
    parameter int   STALL_THRESH = 16,
    parameter int   CNT_W        = clog2(STALL_THRESH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic tvalid,
    input  logic tready,
    output logic blocked
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);

    logic             stall_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             blocked_r;

    // Inputs starve (ready without data); outputs are back-pressured (data without ready).
    always_comb begin
        if (IS_OUT == STALL_OUT) begin
            stall_s = tvalid & ~tready;
        end else begin
            stall_s = tready & ~tvalid;
        end
    end

    // Next count: restart on any non-stall cycle or while disabled, saturate at the threshold.
    always_comb begin
        if (!en || !stall_s) begin
            cnt_next_s = '0;
        end else if (cnt_r == THRESH) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter and flag registers; the flag is decoded from the value the counter is about to hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            blocked_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_next_s;
            blocked_r <= (cnt_next_s == THRESH);
        end
    end

    assign blocked = blocked_r;

endmodule

// File: rtl/axis_stall_detector.sv
// Per-port stall flags for a dataflow instance, with first-block capture and
// a saturating blocked-cycle counter for debug readout.
module axis_stall_detector
    import axis_stall_pkg::*;
#(
    parameter int                   NUM_PORTS    = 2,
    parameter logic [NUM_PORTS-1:0] PORT_IS_OUT  = 2'b10,
    parameter int                   STALL_THRESH = 16,
    parameter int                   CNT_W        = clog2(STALL_THRESH + 1),
    parameter int                   IDX_W        = (clog2(NUM_PORTS) < 1) ? 1 : clog2(NUM_PORTS)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   en,
    input  logic [NUM_PORTS-1:0]   tvalid,
    input  logic [NUM_PORTS-1:0]   tready,
    input  logic                   clear,
    output logic [NUM_PORTS-1:0]   axis_block_sigs,
    output logic                   any_block,
    output logic                   first_valid,
    output logic [IDX_W-1:0]       first_idx,
    output logic [BLOCK_CNT_W-1:0] block_cycles
);

    localparam logic [BLOCK_CNT_W-1:0] BC_MAX = '1;

    logic [NUM_PORTS-1:0]   block_sigs_s;
    logic                   any_block_s;
    logic [IDX_W-1:0]       first_hit_s;
    logic                   first_valid_r;
    logic [IDX_W-1:0]       first_idx_r;
    logic [BLOCK_CNT_W-1:0] block_cycles_r;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        axis_stall_counter #(
            .IS_OUT       (PORT_IS_OUT[i]),
            .STALL_THRESH (STALL_THRESH),
            .CNT_W        (CNT_W)
        ) u_cnt (
            .clk     (ap_clk),
            .rst_n   (ap_rst_n),
            .en      (en),
            .tvalid  (tvalid[i]),
            .tready  (tready[i]),
            .blocked (block_sigs_s[i])
        );
    end

    assign any_block_s = |block_sigs_s;

    // Lowest blocked index wins: scan downward so the lowest hit is written last.
    always_comb begin
        first_hit_s = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            first_hit_s = block_sigs_s[i] ? IDX_W'(i) : first_hit_s;
        end
    end

    // Sticky first-block capture and blocked-cycle count; clear wins over both for its cycle.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            first_valid_r  <= 1'b0;
            first_idx_r    <= '0;
            block_cycles_r <= '0;
        end else if (clear) begin
            first_valid_r  <= 1'b0;
            first_idx_r    <= '0;
            block_cycles_r <= '0;
        end else begin
            if (!first_valid_r && any_block_s) begin
                first_valid_r <= 1'b1;
                first_idx_r   <= first_hit_s;
            end
            if (any_block_s && (block_cycles_r != BC_MAX)) begin
                block_cycles_r <= block_cycles_r + 32'd1;
            end
        end
    end

    assign axis_block_sigs = block_sigs_s;
    assign any_block       = any_block_s;
    assign first_valid     = first_valid_r;
    assign first_idx       = first_idx_r;
    assign block_cycles    = block_cycles_r;

endmodule

// File: tb/tb_axis_stall_detector.sv
// Scoreboard bench for axis_stall_detector: directed scenarios then random segments,
// checked against a run-length reference model.
module tb_axis_stall_detector;

    localparam int         THRESH = 16;
    localparam logic [1:0] IS_OUT = 2'b10;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        en = 1'b1;
    logic        clear = 1'b0;
    logic [1:0]  tvalid = 2'b00;
    logic [1:0]  tready = 2'b00;
    logic [1:0]  axis_block_sigs;
    logic        any_block;
    logic        first_valid;
    logic [0:0]  first_idx;
    logic [31:0] block_cycles;

    always #5 ap_clk = ~ap_clk;

    axis_stall_detector dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .en              (en),
        .tvalid          (tvalid),
        .tready          (tready),
        .clear           (clear),
        .axis_block_sigs (axis_block_sigs),
        .any_block       (any_block),
        .first_valid     (first_valid),
        .first_idx       (first_idx),
        .block_cycles    (block_cycles)
    );

    typedef struct {
        logic [1:0]  sigs;
        logic        anyb;
        logic        fv;
        logic        idx_known;
        logic [0:0]  idx;
        logic [31:0] bc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: length of the current unbroken stall run per port.
    int         run [2] = '{0, 0};
    logic       m_fv = 1'b0;
    logic       m_idx_known = 1'b1;
    logic [0:0] m_idx = 1'b0;
    longint     m_bc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // mode: 0 idle, 1 transfer, 2 stall, 3 random of 0..2, 4 raw random valid/ready
    task automatic cycle(input logic rst, input logic e, input logic c, input int m0, input int m1);
        exp_t       x;
        logic [1:0] fl;
        logic [1:0] tv;
        logic [1:0] tr;
        logic [1:0] dir;
        logic       st;
        int         md;
        @(posedge ap_clk);
        #1;
        dir = IS_OUT;
        for (int p = 0; p < 2; p++) fl[p] = (run[p] >= THRESH);
        x.sigs = fl;
        x.anyb = |fl;
        x.fv = m_fv;
        x.idx_known = m_idx_known;
        x.idx = m_idx;
        x.bc = m_bc[31:0];
        exp_q.push_back(x);

        for (int p = 0; p < 2; p++) begin
            md = (p == 0) ? m0 : m1;
            if (md == 3) md = $urandom_range(0, 2);
            case (md)
                0: begin tv[p] = 1'b0; tr[p] = 1'b0; end
                1: begin tv[p] = 1'b1; tr[p] = 1'b1; end
                2: begin tv[p] = dir[p]; tr[p] = ~dir[p]; end
                default: begin tv[p] = 1'($urandom); tr[p] = 1'($urandom); end
            endcase
        end
        ap_rst_n = rst;
        en = e;
        clear = c;
        tvalid = tv;
        tready = tr;

        if (!rst) begin
            run[0] = 0;
            run[1] = 0;
            m_fv = 1'b0;
            m_idx = 1'b0;
            m_idx_known = 1'b1;
            m_bc = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                st = dir[p] ? (tv[p] && !tr[p]) : (tr[p] && !tv[p]);
                run[p] = (e && st) ? run[p] + 1 : 0;
            end
            if (c) begin
                m_fv = 1'b0;
                m_bc = 0;
                m_idx_known = 1'b0;
            end else begin
                if (!m_fv && fl != 2'b00) begin
                    m_fv = 1'b1;
                    m_idx = fl[0] ? 1'b0 : 1'b1;
                    m_idx_known = 1'b1;
                end
                if (fl != 2'b00 && m_bc < 64'h0000_0000_FFFF_FFFF) m_bc = m_bc + 1;
            end
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge ap_clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("block_sigs", {30'd0, axis_block_sigs}, {30'd0, x.sigs});
                chk("any_block", {31'd0, any_block}, {31'd0, x.anyb});
                chk("first_valid", {31'd0, first_valid}, {31'd0, x.fv});
                if (x.idx_known) chk("first_idx", {31'd0, first_idx}, {31'd0, x.idx});
                chk("block_cycles", block_cycles, x.bc);
            end
        end
    end

    initial begin
        int len;
        int r0;
        int r1;
        logic e;
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 2, 2);
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 2, 0);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1, 0);
        repeat (15) cycle(1'b1, 1'b1, 1'b0, 0, 2);
        cycle(1'b1, 1'b1, 1'b0, 0, 1);
        repeat (18) cycle(1'b1, 1'b1, 1'b0, 0, 2);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 1'b1, 1'b1, 0, 0);
        repeat (22) cycle(1'b1, 1'b1, 1'b0, 2, 2);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 0, 2);
        cycle(1'b1, 1'b1, 1'b1, 0, 2);
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 0, 2);
        repeat (30) cycle(1'b1, 1'b0, 1'b0, 2, 2);
        repeat (18) cycle(1'b1, 1'b1, 1'b0, 2, 2);
        cycle(1'b0, 1'b1, 1'b0, 2, 2);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 2, 2);

        for (int s = 0; s < 80; s++) begin
            len = $urandom_range(1, 40);
            r0 = $urandom_range(0, 5);
            r1 = $urandom_range(0, 5);
            if (r0 == 5) r0 = 2;
            if (r1 == 5) r1 = 2;
            e = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < len; k++) begin
                cycle(($urandom_range(0, 199) != 0), e, ($urandom_range(0, 49) == 0), r0, r1);
            end
        end

        repeat (3) @(negedge ap_clk);
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_stall_detector.md
Name: axis_stall_detector

Overview:
- Watches the AXI-Stream handshakes of one streaming dataflow instance, e.g. a StreamingMaxPool input and output pair.
- Produces one per-port "blocked" flag for each watched stream; these flags feed the axis_block_sigs input of the instance's deadlock monitor.
- A port is blocked once it has been stalled continuously for STALL_THRESH cycles.
- Also latches the first port to block and counts the total number of blocked cycles, for debug readout.

Parameters:
- NUM_PORTS, 2: number of watched AXI-Stream ports.
- PORT_IS_OUT, 2'b10: bitmask. Bit i = 1 means port i is an output of the watched instance; 0 means it is an input.
- STALL_THRESH, 16: consecutive stalled cycles before a port is flagged. Legal range ≥1.
- CNT_W, $clog2(STALL_THRESH+1): width of each per-port stall counter.
- IDX_W, max(1,$clog2(NUM_PORTS)): width of a port index.

Ports:
- ap_clk, input, 1: clock.
- ap_rst_n, input, 1: reset, synchronous, active-low.
- en, input, 1: detector enable. While low, all counters are forced to 0.
- tvalid, input, NUM_PORTS: TVALID of each watched stream.
- tready, input, NUM_PORTS: TREADY of each watched stream.
- clear, input, 1: single-cycle pulse; clears the sticky capture and the blocked-cycle counter.
- axis_block_sigs, output, NUM_PORTS: per-port blocked flag, registered.
- any_block, output, 1: OR of axis_block_sigs.
- first_valid, output, 1: sticky; set when any port first blocks.
- first_idx, output, IDX_W: index of the first blocked port.
- block_cycles, output, 32: saturating count of cycles with any_block high.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge) zeroes all state: counters, axis_block_sigs, any_block, first_valid, first_idx, block_cycles. Reset mid-stall drops every flag on the next cycle.
- Stall condition for port i:
  - Input port (PORT_IS_OUT[i]=0), i.e. starved: tready[i] & ~tvalid[i].
  - Output port (PORT_IS_OUT[i]=1), i.e. back-pressured: tvalid[i] & ~tready[i].
  - A transfer (valid & ready) and an idle cycle (neither signal high) are both non-stall.
- Per-port counter cnt_i, updated each cycle:
  - en=0 → 0.
  - Non-stall → 0.
  - Stall and cnt_i < STALL_THRESH → cnt_i+1.
  - Stall and cnt_i = STALL_THRESH → hold (saturate).
- axis_block_sigs[i] = (cnt_i == STALL_THRESH), decoded from the registered counter.
- Timing:
  - Continuous stall starting at cycle t → flag high from cycle t+STALL_THRESH.
  - First non-stall cycle at t' → flag low from t'+1.
  - A single non-stall cycle restarts the count from zero.
- any_block is the combinational OR of the registered flags.
- Sticky capture:
  - When first_valid=0 and any_block=1, next cycle first_valid=1 and first_idx = lowest index i with axis_block_sigs[i]=1.
  - If several ports block in the same cycle, the lowest index wins.
  - Once set, first_valid and first_idx hold until clear or reset.
- block_cycles increments by 1 in each cycle any_block=1 and saturates at 32'hFFFF_FFFF.
- clear priority:
  - In the clear cycle, first_valid→0 and block_cycles→0; capture and increment are suppressed that cycle.
  - If any_block is still high afterwards, capture and counting resume the following cycle.
- en has no effect on the sticky capture or block_cycles; they follow any_block only.
- Inputs are sampled as-is. X on tvalid/tready is out of scope.

Decomposition:
- Package axis_stall_pkg holds:
  - localparams STALL_IN=1'b0 and STALL_OUT=1'b1 (port-kind encoding);
  - the 32-bit block_cycles width constant;
  - a clog2 helper function.
- One sub-module, axis_stall_counter: one port's stall predicate, saturating counter and flag decode. Parameters IS_OUT, STALL_THRESH, CNT_W. It is instantiated NUM_PORTS times in a generate loop.
- The top level holds any_block, the first-block priority encoder, the sticky registers and block_cycles.

Test Plan:
- Reset: hold ap_rst_n=0 for 3 cycles with stalls applied → all outputs 0; release → port0 flag rises exactly STALL_THRESH=16 cycles after the first stalled cycle.
- Input starvation: port0 tready=1, tvalid=0 for 20 cycles → axis_block_sigs=2'b01 from cycle 16; at cycle 20 apply tvalid=1 → flag low at cycle 21.
- Output backpressure with near-miss: port1 tvalid=1, tready=0 for 15 cycles, 1-cycle tready pulse, then 16 more stalled cycles → flag never rises in the first window; rises 16 cycles after the pulse.
- Simultaneous block: both ports stalled from the same cycle → axis_block_sigs=2'b11 at cycle 16; first_valid=1, first_idx=0 at cycle 17; block_cycles=5 after 5 blocked cycles.
- clear while blocked: port1 still blocked and clear pulsed → first_valid=0 and block_cycles=0 in the next cycle; one cycle later first_valid=1, first_idx=1, block_cycles=1.
- Enable and reset mid-stall: en=0 during a 30-cycle stall → flag stays 0; raise en → flag rises 16 cycles later. Reset asserted while the flag is high → flag 0 the next cycle.
